// File: rtl/text_pkg.sv
// Shared definitions for the text overlay: tile geometry, tile word layout
// and the pipeline stage records used by the tile renderer.
package text_pkg;

    localparam int TILE_W     = 16;   // screen pixels per tile edge (8x8 font scaled 2x)
    localparam int FONT_W     = 8;    // font glyph width/height in font pixels
    localparam int DEF_COLS   = 40;   // 640 / TILE_W
    localparam int DEF_ROWS   = 30;   // 480 / TILE_W

    // Tile word field positions, shared with the text writers
    localparam int OCC_BIT    = 8;
    localparam int BLINK_BIT  = 7;
    localparam int GLYPH_MSB  = 5;

    localparam int RAM_ADDR_W = 16;
    localparam int ROM_ADDR_W = GLYPH_MSB + 1 + 3;

    // Stage 1 record: what survives the tile RAM read
    typedef struct packed {
        logic [2:0] frow;
        logic [2:0] fcol;
        logic       inrange;
        logic       video_on;
        logic       hsync;
        logic       vsync;
    } s1_t;

    // Stage 2 record: what survives the font ROM read
    typedef struct packed {
        logic       occ;
        logic       blk;
        logic [2:0] fcol;
        logic       video_on;
        logic       hsync;
        logic       vsync;
    } s2_t;

    // Font pixel index inside a tile: drop the 2x scaling bit
    function automatic logic [2:0] font_sub(input logic [9:0] p);
        return p[3:1];
    endfunction

endpackage

// File: rtl/text_tile_renderer_if.sv
// Read port bundle towards the tile RAM and the font ROM (both 1-cycle sync).
interface text_tile_renderer_if;
    import text_pkg::*;

    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [TILE_W-1:0]     ram_dout;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [FONT_W-1:0]     rom_data;

    modport master (output ram_addr, output rom_addr, input ram_dout, input rom_data);
    modport slave  (input ram_addr, input rom_addr, output ram_dout, output rom_data);
endinterface

// File: rtl/text_blink_ctrl.sv
// Blink phase generator: counts vsync inactive->active edges and toggles the
// phase every BLINK_FRAMES frames, so the phase only ever moves during vsync.
module text_blink_ctrl #(
    parameter int BLINK_FRAMES = 30,
    parameter bit VSYNC_POL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic blink_phase
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             phase_reg;
    logic             frame_edge;

    assign frame_edge  = (vsync == VSYNC_POL) && (vsync_reg != VSYNC_POL);
    assign blink_phase = phase_reg;

    // Edge-detect register, frame counter and phase toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_reg <= ~VSYNC_POL;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else begin
            vsync_reg <= vsync;
            if (frame_edge) begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_reg   <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/text_tile_renderer.sv
// Text tile renderer: pix -> tile RAM read -> font ROM read -> text pixel.
// Three registered stages, one pixel per clock, syncs delayed alongside.
module text_tile_renderer
    import text_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int BLINK_FRAMES = 30,
    parameter bit VSYNC_POL    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [9:0]                  pix_x,
    input  logic [9:0]                  pix_y,
    input  logic                        video_on,
    input  logic                        hsync,
    input  logic                        vsync,
    text_tile_renderer_if.master        mem,
    output logic                        text_on,
    output logic                        tile_occ,
    output logic                        video_on_d,
    output logic                        hsync_d,
    output logic                        vsync_d
);
    localparam s1_t S1_RST = '{frow: 3'd0, fcol: 3'd0, inrange: 1'b0, video_on: 1'b0,
                               hsync: 1'b1, vsync: ~VSYNC_POL};
    localparam s2_t S2_RST = '{occ: 1'b0, blk: 1'b0, fcol: 3'd0, video_on: 1'b0,
                               hsync: 1'b1, vsync: ~VSYNC_POL};

    logic [5:0]            col;
    logic [5:0]            row;
    logic [RAM_ADDR_W-1:0] addr_sum;
    logic                  inrange;
    logic                  blink_phase;
    logic                  glyph_bit;
    s1_t                   s1_reg;
    s2_t                   s2_reg;
    logic                  unused_bits;

    assign col     = pix_x[9:4];
    assign row     = pix_y[9:4];
    assign inrange = ({1'b0, col} < 7'(COLS)) && ({1'b0, row} < 7'(ROWS));

    // Tile address row*COLS + col as a sum of shifted rows, one term per set bit of COLS
    always_comb begin
        addr_sum = RAM_ADDR_W'(col);
        for (int i = 0; i < 7; i++) begin
            if (COLS[i]) begin
                addr_sum = addr_sum + (RAM_ADDR_W'(row) << i);
            end
        end
    end

    // Addresses are held at zero while reset is asserted
    assign mem.ram_addr = rst_n ? addr_sum : '0;
    assign mem.rom_addr = rst_n ? {mem.ram_dout[GLYPH_MSB:0], s1_reg.frow} : '0;

    // Stage 0 -> 1: capture sub-tile position and controls while the RAM reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= S1_RST;
        end else begin
            s1_reg.frow     <= font_sub(pix_y);
            s1_reg.fcol     <= font_sub(pix_x);
            s1_reg.inrange  <= inrange;
            s1_reg.video_on <= video_on;
            s1_reg.hsync    <= hsync;
            s1_reg.vsync    <= vsync;
        end
    end

    // Stage 1 -> 2: decode tile word while the font ROM reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_reg <= S2_RST;
        end else begin
            s2_reg.occ      <= mem.ram_dout[OCC_BIT] & s1_reg.inrange;
            s2_reg.blk      <= mem.ram_dout[BLINK_BIT];
            s2_reg.fcol     <= s1_reg.fcol;
            s2_reg.video_on <= s1_reg.video_on;
            s2_reg.hsync    <= s1_reg.hsync;
            s2_reg.vsync    <= s1_reg.vsync;
        end
    end

    // Font bit 7 is the leftmost column
    assign glyph_bit = mem.rom_data[3'd7 - s2_reg.fcol];

    // Stage 2 -> out: combine glyph bit, occupancy, blanking and blink
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_on    <= 1'b0;
            tile_occ   <= 1'b0;
            video_on_d <= 1'b0;
            hsync_d    <= 1'b1;
            vsync_d    <= ~VSYNC_POL;
        end else begin
            text_on    <= s2_reg.video_on & s2_reg.occ & glyph_bit & ~(s2_reg.blk & blink_phase);
            tile_occ   <= s2_reg.video_on & s2_reg.occ;
            video_on_d <= s2_reg.video_on;
            hsync_d    <= s2_reg.hsync;
            vsync_d    <= s2_reg.vsync;
        end
    end

    text_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .VSYNC_POL    (VSYNC_POL)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .blink_phase (blink_phase)
    );

    // Tile word bits [15:9] and [6], and the half-pixel bits, carry no meaning here
    assign unused_bits = ^{mem.ram_dout[TILE_W-1:OCC_BIT+1], mem.ram_dout[6], pix_x[0], pix_y[0]};
endmodule
